// File: rtl/logic_cluster_pkg.sv
// -----------------------------------------------------------------------------
// logic_cluster_pkg
//   Shared definitions for the logic cluster: derived configuration sizes,
//   the configuration-state enum and the field layout of one cell's config
//   slice.
//
//   Cell config slice layout (CELL_CFG bits, LSB first):
//     [NIN-1:0]  per-input inverters, bit k inverts data input k
//     [NIN]      ZINV, inverts the registered output
// -----------------------------------------------------------------------------
package logic_cluster_pkg;

    typedef enum logic [1:0] {
        UNCONF     = 2'd0,  // no frame committed since reset
        RELOAD     = 2'd1,  // new frame shifting in, old config still live
        CONFIGURED = 2'd2   // config live, shift register idle
    } cfg_state_e;

    // Offset of the input-inverter field inside a cell config slice.
    localparam int CFG_INV_LSB = 0;

    // Data inputs per cell.
    function automatic int nin_f(input int sel_bits);
        return 1 << sel_bits;
    endfunction

    // Offset of the ZINV bit inside a cell config slice.
    function automatic int zinv_pos_f(input int sel_bits);
        return nin_f(sel_bits);
    endfunction

    // Width of one cell config slice.
    function automatic int cell_cfg_f(input int sel_bits);
        return nin_f(sel_bits) + 1;
    endfunction

    // Length of the full configuration frame.
    function automatic int cfg_len_f(input int num_cells, input int sel_bits);
        return num_cells * cell_cfg_f(sel_bits);
    endfunction

endpackage

// File: rtl/logic_cluster_cell.sv
// -----------------------------------------------------------------------------
// logic_cluster_cell
//   One logic cell: per-input inverters, 2^SEL_BITS:1 mux, flip-flop with
//   set/clear/enable, cascade input select and output inverter.
//
// Ports
//   qck      in   clock, rising edge
//   qrt      in   synchronous active-high reset
//   run      in   0 while the cluster is unconfigured: CZ forced 0, FF held 0
//   cfg      in   CELL_CFG-bit live config slice (inverters + ZINV)
//   din      in   NIN data inputs
//   sel      in   mux select
//   qen      in   FF load enable
//   qst      in   FF synchronous set
//   qclr     in   FF synchronous clear
//   qds      in   1: FF D from casc_in, 0: from cz
//   casc_in  in   cascade input (previous cell's raw FF, or QDI for cell 0)
//   cz       out  combinational mux output
//   qz       out  FF output after ZINV
//   ff_q     out  raw FF value, feeds the next cell's cascade
// -----------------------------------------------------------------------------
module logic_cluster_cell
    import logic_cluster_pkg::*;
#(
    parameter int SEL_BITS = 2
) (
    input  logic                          qck,
    input  logic                          qrt,
    input  logic                          run,
    input  logic [cell_cfg_f(SEL_BITS)-1:0] cfg,
    input  logic [nin_f(SEL_BITS)-1:0]    din,
    input  logic [SEL_BITS-1:0]           sel,
    input  logic                          qen,
    input  logic                          qst,
    input  logic                          qclr,
    input  logic                          qds,
    input  logic                          casc_in,
    output logic                          cz,
    output logic                          qz,
    output logic                          ff_q
);

    localparam int NIN  = nin_f(SEL_BITS);
    localparam int ZINV = zinv_pos_f(SEL_BITS);

    logic [NIN-1:0] din_inv;
    logic           ff_d;

    assign din_inv = din ^ cfg[CFG_INV_LSB +: NIN];

    // A variable index over a 2^SEL_BITS vector synthesises to the mux tree.
    assign cz   = run & din_inv[sel];
    assign ff_d = qds ? casc_in : cz;

    // Priority: reset / unconfigured > set > clear > load > hold.
    // NOTE: sequential state uses non-blocking assignments so every FF in the
    // cluster samples pre-edge values, which the cascade chain relies on.
    always_ff @(posedge qck) begin
        if (qrt || !run) begin
            ff_q <= 1'b0;
        end else if (qst) begin
            ff_q <= 1'b1;
        end else if (qclr) begin
            ff_q <= 1'b0;
        end else if (qen) begin
            ff_q <= ff_d;
        end
    end

    // ZINV is applied after the FF, so a commit changes qz without an FF update.
    assign qz = ff_q ^ cfg[ZINV];

endmodule

// File: rtl/logic_cluster.sv
// -----------------------------------------------------------------------------
// logic_cluster
//   Cluster of NUM_CELLS logic cells sharing a serial configuration chain.
//   Config bits shift into sr; once CFG_LEN enabled shifts have accumulated
//   the frame is copied into active_cfg in one edge, so the cells never see a
//   partially loaded frame.
//
// Ports
//   qck       in   clock, rising edge
//   qrt       in   synchronous active-high reset
//   cfg_en    in   shift one config bit this cycle
//   cfg_di    in   serial config data in
//   cfg_do    out  serial config data out (shift-register MSB)
//   cfg_done  out  one-cycle pulse after the frame is committed
//   din       in   NUM_CELLS*NIN data inputs, cell i uses din[i*NIN +: NIN]
//   sel       in   NUM_CELLS*SEL_BITS selects, cell i uses sel[i*SEL_BITS +: SEL_BITS]
//   qen       in   per-cell FF enable
//   qst       in   per-cell FF synchronous set
//   qclr      in   per-cell FF synchronous clear
//   qds       in   per-cell FF D source: 1 cascade, 0 cz
//   qdi       in   cascade input into cell 0
//   cz        out  per-cell combinational mux outputs
//   qz        out  per-cell registered outputs
// -----------------------------------------------------------------------------
module logic_cluster
    import logic_cluster_pkg::*;
#(
    parameter int NUM_CELLS = 4,
    parameter int SEL_BITS  = 2
) (
    input  logic                                  qck,
    input  logic                                  qrt,
    input  logic                                  cfg_en,
    input  logic                                  cfg_di,
    output logic                                  cfg_do,
    output logic                                  cfg_done,
    input  logic [NUM_CELLS*nin_f(SEL_BITS)-1:0]  din,
    input  logic [NUM_CELLS*SEL_BITS-1:0]         sel,
    input  logic [NUM_CELLS-1:0]                  qen,
    input  logic [NUM_CELLS-1:0]                  qst,
    input  logic [NUM_CELLS-1:0]                  qclr,
    input  logic [NUM_CELLS-1:0]                  qds,
    input  logic                                  qdi,
    output logic [NUM_CELLS-1:0]                  cz,
    output logic [NUM_CELLS-1:0]                  qz
);

    localparam int NIN      = nin_f(SEL_BITS);
    localparam int CELL_CFG = cell_cfg_f(SEL_BITS);
    localparam int CFG_LEN  = cfg_len_f(NUM_CELLS, SEL_BITS);
    localparam int CNT_W    = $clog2(CFG_LEN);

    logic [CFG_LEN-1:0]   sr;
    logic [CFG_LEN-1:0]   sr_next;
    logic [CFG_LEN-1:0]   active_cfg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 commit;
    logic                 run;
    cfg_state_e           state;
    cfg_state_e           state_next;
    logic [NUM_CELLS-1:0] ff_q;
    logic [NUM_CELLS-1:0] casc;

    // ---------------------------------------------------------------- config chain
    assign sr_next = {sr[CFG_LEN-2:0], cfg_di};
    assign commit  = cfg_en && (bit_cnt == CNT_W'(CFG_LEN - 1));
    assign cfg_do  = sr[CFG_LEN-1];

    always_ff @(posedge qck) begin
        if (qrt) begin
            sr         <= '0;
            bit_cnt    <= '0;
            active_cfg <= '0;
            cfg_done   <= 1'b0;
        end else begin
            cfg_done <= commit;
            if (cfg_en) begin
                sr      <= sr_next;
                bit_cnt <= commit ? '0 : bit_cnt + 1'b1;
            end
            // Capture the shifted value so the last bit lands in the same edge.
            if (commit) begin
                active_cfg <= sr_next;
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge qck) begin
        if (qrt) begin
            state <= UNCONF;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every comb output gets a default before the case so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            UNCONF:     if (commit) state_next = CONFIGURED;
            CONFIGURED: if (commit) state_next = CONFIGURED;
                        else if (cfg_en) state_next = RELOAD;
            RELOAD:     if (commit) state_next = CONFIGURED;
            default:    state_next = UNCONF;
        endcase
    end

    // Cells keep running on the old active_cfg throughout RELOAD.
    always_comb begin
        run = 1'b0;
        case (state)
            CONFIGURED, RELOAD: run = 1'b1;
            default:            run = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- cells
    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        // The cascade taps the raw FF of the previous cell, not its qz.
        if (g == 0) begin : g_head
            assign casc[g] = qdi;
        end else begin : g_link
            assign casc[g] = ff_q[g-1];
        end

        logic_cluster_cell #(
            .SEL_BITS (SEL_BITS)
        ) u_cell (
            .qck     (qck),
            .qrt     (qrt),
            .run     (run),
            .cfg     (active_cfg[g*CELL_CFG +: CELL_CFG]),
            .din     (din[g*NIN +: NIN]),
            .sel     (sel[g*SEL_BITS +: SEL_BITS]),
            .qen     (qen[g]),
            .qst     (qst[g]),
            .qclr    (qclr[g]),
            .qds     (qds[g]),
            .casc_in (casc[g]),
            .cz      (cz[g]),
            .qz      (qz[g]),
            .ff_q    (ff_q[g])
        );
    end

endmodule

// File: tb/tb_logic_cluster.sv
// -----------------------------------------------------------------------------
// tb_logic_cluster
//   Directed bench for logic_cluster (NUM_CELLS=4, SEL_BITS=2, CFG_LEN=20).
//   A behavioural model tracks the config history as a bit queue and the cells
//   as plain arithmetic; a negedge process compares every cycle, and directed
//   sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_logic_cluster;

    localparam int NC  = 4;
    localparam int NI  = 4;
    localparam int CC  = 5;
    localparam int CL  = 20;

    logic          qck = 1'b0;
    logic          qrt;
    logic          cfg_en;
    logic          cfg_di;
    logic          cfg_do;
    logic          cfg_done;
    logic [15:0]   din;
    logic [7:0]    sel;
    logic [3:0]    qen;
    logic [3:0]    qst;
    logic [3:0]    qclr;
    logic [3:0]    qds;
    logic          qdi;
    logic [3:0]    cz;
    logic [3:0]    qz;

    int tests = 0;
    int fails = 0;

    logic_cluster #(.NUM_CELLS(NC), .SEL_BITS(2)) dut (
        .qck      (qck),
        .qrt      (qrt),
        .cfg_en   (cfg_en),
        .cfg_di   (cfg_di),
        .cfg_do   (cfg_do),
        .cfg_done (cfg_done),
        .din      (din),
        .sel      (sel),
        .qen      (qen),
        .qst      (qst),
        .qclr     (qclr),
        .qds      (qds),
        .qdi      (qdi),
        .cz       (cz),
        .qz       (qz)
    );

    always #5 qck = ~qck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    bit          m_valid = 1'b0;
    bit          hist[$];          // last CL enabled config bits, oldest first
    int          m_cnt;            // enabled shifts since reset or commit
    logic [19:0] m_cfg;
    bit          m_configured;
    logic [3:0]  m_ff;
    bit          m_done;

    function automatic logic [3:0] model_cz();
        logic [3:0] r;
        for (int i = 0; i < NC; i++) begin
            int nib;
            int inv;
            int s;
            nib  = int'(din[i*NI +: NI]);
            inv  = int'(m_cfg[i*CC +: NI]);
            s    = int'(sel[i*2 +: 2]);
            r[i] = m_configured && ((((nib ^ inv) >> s) & 1) == 1);
        end
        return r;
    endfunction

    function automatic logic [3:0] model_qz();
        logic [3:0] r;
        for (int i = 0; i < NC; i++) r[i] = m_ff[i] ^ m_cfg[i*CC + NI];
        return r;
    endfunction

    always @(posedge qck) begin
        logic [3:0] cz_old;
        logic [3:0] ff_new;
        if (qrt) begin
            m_valid      = 1'b1;
            hist.delete();
            m_cnt        = 0;
            m_cfg        = '0;
            m_configured = 1'b0;
            m_ff         = '0;
            m_done       = 1'b0;
        end else begin
            cz_old = model_cz();
            for (int i = 0; i < NC; i++) begin
                if (!m_configured)  ff_new[i] = 1'b0;
                else if (qst[i])    ff_new[i] = 1'b1;
                else if (qclr[i])   ff_new[i] = 1'b0;
                else if (qen[i])    ff_new[i] = qds[i] ? ((i == 0) ? qdi : m_ff[i-1]) : cz_old[i];
                else                ff_new[i] = m_ff[i];
            end
            m_ff   = ff_new;
            m_done = 1'b0;
            if (cfg_en) begin
                hist.push_back(cfg_di);
                if (hist.size() > CL) void'(hist.pop_front());
                m_cnt++;
                if (m_cnt == CL) begin
                    // Newest bit is frame bit 0, oldest is frame bit CL-1.
                    for (int j = 0; j < CL; j++) m_cfg[j] = hist[CL-1-j];
                    m_cnt        = 0;
                    m_configured = 1'b1;
                    m_done       = 1'b1;
                end
            end
        end
    end

    always @(negedge qck) begin
        if (m_valid) begin
            check("cmp_cz",       32'(cz),       32'(model_cz()));
            check("cmp_qz",       32'(qz),       32'(model_qz()));
            check("cmp_cfg_do",   32'(cfg_do),   32'((hist.size() == CL) ? hist[0] : 1'b0));
            check("cmp_cfg_done", 32'(cfg_done), 32'(m_done));
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(posedge qck);
        #1;
    endtask

    task automatic send_bit(input logic b);
        cfg_en = 1'b1;
        cfg_di = b;
        tick();
        cfg_en = 1'b0;
        cfg_di = 1'b0;
    endtask

    // Frame bit CL-1 goes first so that bit j ends up in active_cfg[j].
    task automatic send_frame(input logic [19:0] f);
        for (int k = CL - 1; k >= 0; k--) send_bit(f[k]);
    endtask

    initial begin
        logic [19:0] fa;
        logic [19:0] fb;

        qrt = 1'b1; cfg_en = 1'b0; cfg_di = 1'b0;
        din = '0; sel = '0; qen = '0; qst = '0; qclr = '0; qds = '0; qdi = 1'b0;
        tick();
        qrt = 1'b0;

        // 1: unconfigured cluster stays quiet even with FFs enabled
        qen = 4'hF;
        for (int i = 0; i < 6; i++) begin
            din = (i % 2 == 1) ? 16'hFFFF : 16'h5A5A;
            sel = 8'(i * 37);
            tick();
            check("unconf_qz", 32'(qz), 32'h0);
            check("unconf_cz", 32'(cz), 32'h0);
            check("unconf_done", 32'(cfg_done), 32'h0);
        end

        // 2: first load of zeros, then reload inverting cell0 input 1
        qen = '0;
        din = 16'h0005;
        sel = 8'h01;
        for (int k = 0; k < CL - 1; k++) send_bit(1'b0);
        check("load_done_early", 32'(cfg_done), 32'h0);
        send_bit(1'b0);
        check("load_done_pulse", 32'(cfg_done), 32'h1);
        check("load_cz0", 32'(cz[0]), 32'h0);
        tick();
        check("load_done_drop", 32'(cfg_done), 32'h0);
        fa = 20'h00002;
        for (int k = CL - 1; k >= 10; k--) send_bit(fa[k]);
        check("reload_old_cfg", 32'(cz[0]), 32'h0);
        for (int k = 9; k >= 0; k--) send_bit(fa[k]);
        check("reload_new_cfg", 32'(cz[0]), 32'h1);
        check("reload_done", 32'(cfg_done), 32'h1);

        // 3: FF load, set-over-clear, hold, ZINV
        qen = 4'h1;
        tick();
        check("ff_load", 32'(qz[0]), 32'h1);
        qen = 4'h0; qclr = 4'h1;
        tick();
        check("ff_clear", 32'(qz[0]), 32'h0);
        qst = 4'h1;
        tick();
        check("ff_set_over_clr", 32'(qz[0]), 32'h1);
        qst = 4'h0; qclr = 4'h0;
        din = 16'h0007;
        tick();
        tick();
        check("ff_hold", 32'(qz[0]), 32'h1);
        check("ff_hold_cz", 32'(cz[0]), 32'h0);
        send_frame(20'h00012);
        check("zinv_qz", 32'(qz[0]), 32'h0);

        // 4: cascade a single 1 through all four cells
        send_frame(20'h00000);
        qclr = 4'hF;
        tick();
        qclr = 4'h0;
        qds = 4'hF; qen = 4'hF; qdi = 1'b1;
        tick();
        check("casc_0", 32'(qz), 32'h1);
        qdi = 1'b0;
        tick();
        check("casc_1", 32'(qz), 32'h2);
        tick();
        check("casc_2", 32'(qz), 32'h4);
        tick();
        check("casc_3", 32'(qz), 32'h8);
        tick();
        check("casc_out", 32'(qz), 32'h0);
        qds = 4'h0; qen = 4'h0;

        // 5: passthrough of frame A while frame B shifts in with a pause
        fa = 20'hA5C3A;
        fb = 20'h3C96E;
        send_frame(fa);
        for (int k = 0; k < CL; k++) begin
            check("passthru_do", 32'(cfg_do), 32'(fa[CL-1-k]));
            send_bit(fb[CL-1-k]);
            if (k == 9) begin
                tick(); tick(); tick();
                check("pause_done", 32'(cfg_done), 32'h0);
                check("pause_do", 32'(cfg_do), 32'(fa[9]));
            end
        end
        check("pause_commit", 32'(cfg_done), 32'h1);
        check("pause_do_b", 32'(cfg_do), 32'(fb[19]));

        // 6: reset mid-load discards the partial frame
        din = 16'hFFFF;
        sel = 8'h00;
        for (int k = 0; k < 10; k++) send_bit(1'b1);
        qrt = 1'b1;
        tick();
        qrt = 1'b0;
        check("midrst_cz", 32'(cz), 32'h0);
        check("midrst_qz", 32'(qz), 32'h0);
        check("midrst_do", 32'(cfg_do), 32'h0);
        check("midrst_done", 32'(cfg_done), 32'h0);
        for (int k = 0; k < CL - 1; k++) begin
            send_bit(1'b0);
            check("midrst_no_early", 32'(cfg_done), 32'h0);
        end
        send_bit(1'b0);
        check("midrst_commit", 32'(cfg_done), 32'h1);
        check("midrst_cz_live", 32'(cz), 32'hF);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
